soul_controller: RTL and testbench
==================================

// Module: soul_controller
// PURPOSE
//   Sequences the player character sprite: owns its X/Y origin, HP and visibility.
//   Updates once per video frame from button inputs, keeps the sprite inside the battle arena,
//   and applies damage on collision with an invulnerability/blink window.
//   Sits between the input debouncers, the collision detector and the character sprite
//   renderer. Drives the renderer's X/Y origin and its visibility gate.
// PARAMETERS
//   ARENA_X0   220  arena left edge, pixels (inclusive)
//   ARENA_X1   420  arena right edge, pixels (exclusive)
//   ARENA_Y0   100  arena top edge, pixels (inclusive)
//   ARENA_Y1   300  arena bottom edge, pixels (exclusive)
//   SPR_W      34   sprite width, pixels
//   SPR_H      27   sprite height, pixels
//   START_X    300  spawn X origin
//   START_Y    150  spawn Y origin
//   STEP       2    pixels moved per frame per axis
//   HP_MAX     20   HP at spawn (must be <= 127)
//   DAMAGE     4    HP lost per accepted hit
//   INV_FRAMES 60   invulnerability length, frames
// PORTS
//   Pclk        in   1   pixel clock; the only clock
//   rst_n       in   1   asynchronous, active-low reset
//   frame_tick  in   1   one-cycle pulse per frame, issued at the start of vblank
//   btn_up      in   1   level, synchronised
//   btn_down    in   1   level, synchronised
//   btn_left    in   1   level, synchronised
//   btn_right   in   1   level, synchronised
//   hit         in   1   one-cycle collision pulse
//   start       in   1   one-cycle pulse; spawns or respawns the character
//   char_x      out  10  sprite X origin
//   char_y      out  9   sprite Y origin
//   char_vis    out  1   renderer enable
//   hp          out  7   current HP
//   dead        out  1   high in DEAD state
//   state       out  2   FSM state, for debug
// BEHAVIOUR
//   Reset values: char_x=START_X, char_y=START_Y, char_vis=0, hp=HP_MAX, dead=0, state=IDLE.
//   All outputs are registered and change the cycle after the triggering input.
//   FSM states: IDLE=0, ALIVE=1, INVULN=2, DEAD=3.
//   - IDLE: char_vis=0. start -> ALIVE with spawn position and hp=HP_MAX.
//   - ALIVE: char_vis=1. hit -> hp=max(hp-DAMAGE,0).
//     If the new hp is 0 -> DEAD; otherwise -> INVULN with inv_cnt=INV_FRAMES.
//   - INVULN: further hits are ignored. inv_cnt decrements on each frame_tick.
//     When inv_cnt reaches 0, go to ALIVE on that tick.
//     char_vis = inv_cnt[2], which blinks with an 8-frame period.
//   - DEAD: position is frozen, char_vis=1, dead=1. start -> spawn values and ALIVE.
//   start in any state respawns: position, hp and inv_cnt are reloaded, state -> ALIVE.
//   start has priority over hit and frame_tick in the same cycle.
//   hit together with frame_tick in ALIVE: the hit is applied; the tick's movement still applies.
//   hit together with frame_tick in INVULN: the decrement applies and the hit is ignored.
//   Movement happens only on frame_tick, in ALIVE or INVULN, so the origin never changes mid-frame.
//   - dx = STEP*(right-left) and dy = STEP*(down-up). Opposing buttons on one axis give 0.
//   - Compute in 11-bit signed; no unsigned wrap below 0.
//   - Clamp X to [ARENA_X0, ARENA_X1-SPR_W] and Y to [ARENA_Y0, ARENA_Y1-SPR_H].
//     A step that overshoots saturates exactly at the bound.
//   - Diagonal movement is allowed; the axes are independent.
//   Reset asserted mid-frame or mid-invulnerability returns to the reset values immediately.
// CONFIGURATION
//   SOUL_SLOW_EN defined:
//     - Adds input btn_slow (1 bit, level).
//     - While btn_slow is high, the per-frame step is STEP>>1 (minimum 1).
//     - btn_slow is sampled on frame_tick.
//   SOUL_SLOW_EN undefined:
//     - The port is absent and the step is always STEP.
// STRUCTURE
//   Package soul_pkg holds:
//     - the state encoding localparams (IDLE/ALIVE/INVULN/DEAD);
//     - the arena and sprite default constants, shared with the collision detector.
//   Sub-module soul_axis_step, instantiated twice (X and Y):
//     - combinational signed step plus clamp, with parameters LO, HI, W.
//   The FSM, HP and invulnerability counter stay in soul_controller.
// TESTING
//   1. Reset, then start -> char_x=300, char_y=150, hp=20, char_vis=1, state=ALIVE.
//   2. Hold btn_right for 100 frames -> char_x stops at 386 (420-34).
//      Hold btn_left and btn_right together -> no X change.
//   3. Start at y=150, hold btn_up 30 frames -> char_y=100 exactly, never below.
//   4. hit -> hp=16, INVULN. Hit on next cycle -> hp stays 16. char_vis toggles every 4 frames.
//      After 60 frames -> ALIVE, char_vis=1.
//   5. Five hits, each spaced >60 frames apart -> hp=0, dead=1, position frozen.
//      Then start -> hp=20, position (300,150).
//   6. hit and frame_tick in the same cycle in ALIVE with btn_down held -> hp=16 and char_y=152.
//      Drop rst_n mid-INVULN -> all outputs at reset values next edge.

Source files
------------

// File: rtl/soul_pkg.sv
// soul_pkg: state encoding, arena/sprite geometry and widths shared by the
// soul controller and the collision detector.
package soul_pkg;

  // Arena and sprite geometry, pixels
  localparam int unsigned ARENA_X0   = 220;
  localparam int unsigned ARENA_X1   = 420;
  localparam int unsigned ARENA_Y0   = 100;
  localparam int unsigned ARENA_Y1   = 300;
  localparam int unsigned SPR_W      = 34;
  localparam int unsigned SPR_H      = 27;
  localparam int unsigned START_X    = 300;
  localparam int unsigned START_Y    = 150;

  // Gameplay constants
  localparam int unsigned STEP       = 2;
  localparam int unsigned HP_MAX     = 20;
  localparam int unsigned DAMAGE     = 4;
  localparam int unsigned INV_FRAMES = 60;

  // Derived limits: the sprite origin must keep the whole sprite inside
  localparam int unsigned X_MAX      = ARENA_X1 - SPR_W;
  localparam int unsigned Y_MAX      = ARENA_Y1 - SPR_H;
  localparam int unsigned SLOW_STEP  = ((STEP >> 1) == 0) ? 1 : (STEP >> 1);

  // Widths
  localparam int unsigned X_W        = 10;
  localparam int unsigned Y_W        = 9;
  localparam int unsigned HP_W       = 7;
  localparam int unsigned INV_W      = 6;
  localparam int unsigned STEP_W     = 4;

  // State encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ALIVE  = 2'd1;
  localparam logic [1:0] ST_INVULN = 2'd2;
  localparam logic [1:0] ST_DEAD   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ALIVE  = ST_ALIVE,
    INVULN = ST_INVULN,
    DEAD   = ST_DEAD
  } state_t;

endpackage

// File: rtl/soul_if.sv
// soul_if: input events and sprite outputs of the soul controller.
// Optional SOUL_SLOW_EN adds the btn_slow level input.
interface soul_if;
  import soul_pkg::*;

  logic              frame_tick;
  logic              btn_up;
  logic              btn_down;
  logic              btn_left;
  logic              btn_right;
`ifdef SOUL_SLOW_EN
  logic              btn_slow;
`endif
  logic              hit;
  logic              start;
  logic [X_W-1:0]    char_x;
  logic [Y_W-1:0]    char_y;
  logic              char_vis;
  logic [HP_W-1:0]   hp;
  logic              dead;
  logic [1:0]        state;

  // Event source side (debouncers, collision detector, game logic)
  modport master (
    output frame_tick, btn_up, btn_down, btn_left, btn_right,
`ifdef SOUL_SLOW_EN
    output btn_slow,
`endif
    output hit, start,
    input  char_x, char_y, char_vis, hp, dead, state
  );

  // Controller side
  modport slave (
    input  frame_tick, btn_up, btn_down, btn_left, btn_right,
`ifdef SOUL_SLOW_EN
    input  btn_slow,
`endif
    input  hit, start,
    output char_x, char_y, char_vis, hp, dead, state
  );

endinterface

// File: rtl/soul_axis_step.sv
// soul_axis_step: one axis of movement; signed step then clamp to [LO, HI].
module soul_axis_step #(
  parameter int unsigned W  = 10,
  parameter int unsigned LO = 0,
  parameter int unsigned HI = 1023
) (
  input  logic [W-1:0] pos,
  input  logic         inc,
  input  logic         dec,
  input  logic [3:0]   step,
  output logic [W-1:0] pos_nxt_c
);

  localparam logic signed [10:0] LO_S = 11'(LO);
  localparam logic signed [10:0] HI_S = 11'(HI);

  logic signed [10:0] delta;
  logic signed [10:0] sum;

  // Opposing buttons cancel; signed sum so a step below zero cannot wrap
  always_comb begin
    delta = '0;
    if (inc && !dec)      delta = 11'(step);
    else if (dec && !inc) delta = -(11'(step));
    sum = 11'(pos) + delta;
    if (sum < LO_S)       pos_nxt_c = W'(LO);
    else if (sum > HI_S)  pos_nxt_c = W'(HI);
    else                  pos_nxt_c = W'(sum);
  end

endmodule

// File: rtl/soul_controller.sv
// soul_controller: player sprite FSM - position, HP, invulnerability blink.
// Optional feature macro: SOUL_SLOW_EN (halved step while btn_slow is held).
module soul_controller
  import soul_pkg::*;
(
  input  logic Pclk,
  input  logic rst_n,
  soul_if.slave bus
);

  state_t            state_q, state_n;
  logic [X_W-1:0]    x_q, x_n, x_step;
  logic [Y_W-1:0]    y_q, y_n, y_step;
  logic [HP_W-1:0]   hp_q, hp_n;
  logic [INV_W-1:0]  inv_q, inv_n;
  logic              vis_q, vis_n;
  logic              dead_q, dead_n;
  logic [STEP_W-1:0] step_c;

`ifdef SOUL_SLOW_EN
  assign step_c = bus.btn_slow ? STEP_W'(SLOW_STEP) : STEP_W'(STEP);
`else
  assign step_c = STEP_W'(STEP);
`endif

  soul_axis_step #(.W(X_W), .LO(ARENA_X0), .HI(X_MAX)) u_step_x (
    .pos       (x_q),
    .inc       (bus.btn_right),
    .dec       (bus.btn_left),
    .step      (step_c),
    .pos_nxt_c (x_step)
  );

  soul_axis_step #(.W(Y_W), .LO(ARENA_Y0), .HI(Y_MAX)) u_step_y (
    .pos       (y_q),
    .inc       (bus.btn_down),
    .dec       (bus.btn_up),
    .step      (step_c),
    .pos_nxt_c (y_step)
  );

  // State, position, HP and blink registers
  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= X_W'(START_X);
      y_q     <= Y_W'(START_Y);
      hp_q    <= HP_W'(HP_MAX);
      inv_q   <= '0;
      vis_q   <= 1'b0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      x_q     <= x_n;
      y_q     <= y_n;
      hp_q    <= hp_n;
      inv_q   <= inv_n;
      vis_q   <= vis_n;
      dead_q  <= dead_n;
    end
  end

  // Next state: start wins, then hit/tick handling per state
  always_comb begin
    state_n = state_q;
    x_n     = x_q;
    y_n     = y_q;
    hp_n    = hp_q;
    inv_n   = inv_q;
    if (bus.start) begin
      state_n = ALIVE;
      x_n     = X_W'(START_X);
      y_n     = Y_W'(START_Y);
      hp_n    = HP_W'(HP_MAX);
      inv_n   = INV_W'(INV_FRAMES);
    end else begin
      case (state_q)
        ALIVE: begin
          if (bus.frame_tick) begin
            x_n = x_step;
            y_n = y_step;
          end
          if (bus.hit) begin
            hp_n  = (hp_q > HP_W'(DAMAGE)) ? hp_q - HP_W'(DAMAGE) : '0;
            inv_n = INV_W'(INV_FRAMES);
            state_n = (hp_n == '0) ? DEAD : INVULN;
          end
        end
        INVULN: begin
          if (bus.frame_tick) begin
            x_n = x_step;
            y_n = y_step;
            if (inv_q <= INV_W'(1)) begin
              inv_n   = '0;
              state_n = ALIVE;
            end else begin
              inv_n = inv_q - INV_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Visibility and dead flag follow the next state so they register with it
  always_comb begin
    vis_n  = 1'b1;
    dead_n = 1'b0;
    case (state_n)
      IDLE:    vis_n  = 1'b0;
      INVULN:  vis_n  = inv_n[2];
      DEAD:    dead_n = 1'b1;
      default: ;
    endcase
  end

  assign bus.char_x   = x_q;
  assign bus.char_y   = y_q;
  assign bus.char_vis = vis_q;
  assign bus.hp       = hp_q;
  assign bus.dead     = dead_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_soul_controller.sv
// tb_soul_controller: directed stimulus with a frame-level behavioural model
// compared on every falling edge, plus literal expectations.
module tb_soul_controller;

  logic Pclk;
  logic rst_n;
  soul_if sif ();

  soul_controller dut (
    .Pclk  (Pclk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model of the character
  int m_x, m_y, m_hp, m_vis, m_dead, m_state, m_inv;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void model_reset();
    m_x = 300; m_y = 150; m_hp = 20; m_vis = 0; m_dead = 0; m_state = 0; m_inv = 0;
  endfunction

  function automatic void model_step();
    int old_state;
    old_state = m_state;
    if (sif.start) begin
      m_x = 300; m_y = 150; m_hp = 20; m_inv = 60; m_state = 1;
    end else begin
      if ((old_state == 1 || old_state == 2) && sif.frame_tick) begin
        m_x = clamp(m_x + 2 * (int'(sif.btn_right) - int'(sif.btn_left)), 220, 420 - 34);
        m_y = clamp(m_y + 2 * (int'(sif.btn_down) - int'(sif.btn_up)), 100, 300 - 27);
      end
      if (old_state == 1 && sif.hit) begin
        m_hp = (m_hp - 4 < 0) ? 0 : m_hp - 4;
        m_inv = 60;
        m_state = (m_hp == 0) ? 3 : 2;
      end else if (old_state == 2 && sif.frame_tick) begin
        m_inv = m_inv - 1;
        if (m_inv == 0) m_state = 1;
      end
    end
    m_dead = (m_state == 3) ? 1 : 0;
    case (m_state)
      0:       m_vis = 0;
      2:       m_vis = (m_inv / 4) % 2;
      default: m_vis = 1;
    endcase
  endfunction

  // Continuous comparison against the model, away from the rising edge
  always @(negedge Pclk) begin
    if (chk_en) begin
      check("char_x",   int'(sif.char_x),   m_x);
      check("char_y",   int'(sif.char_y),   m_y);
      check("hp",       int'(sif.hp),       m_hp);
      check("char_vis", int'(sif.char_vis), m_vis);
      check("dead",     int'(sif.dead),     m_dead);
      check("state",    int'(sif.state),    m_state);
    end
  end

  // One clock: DUT and model advance together, then pulses drop
  task automatic cyc();
    @(posedge Pclk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    sif.frame_tick = 1'b0;
    sif.hit        = 1'b0;
    sif.start      = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      sif.frame_tick = 1'b1;
      cyc();
      cyc();
    end
  endtask

  task automatic pulse_start();
    sif.start = 1'b1;
    cyc();
  endtask

  task automatic pulse_hit();
    sif.hit = 1'b1;
    cyc();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_x"},     int'(sif.char_x),   300);
    check({tag, "_y"},     int'(sif.char_y),   150);
    check({tag, "_vis"},   int'(sif.char_vis), 0);
    check({tag, "_hp"},    int'(sif.hp),       20);
    check({tag, "_dead"},  int'(sif.dead),     0);
    check({tag, "_state"}, int'(sif.state),    0);
  endtask

  initial begin
    sif.frame_tick = 1'b0;
    sif.btn_up     = 1'b0;
    sif.btn_down   = 1'b0;
    sif.btn_left   = 1'b0;
    sif.btn_right  = 1'b0;
`ifdef SOUL_SLOW_EN
    sif.btn_slow   = 1'b0;
`endif
    sif.hit        = 1'b0;
    sif.start      = 1'b0;
    model_reset();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    cyc();
    cyc();
    check_reset_values("rst");
    rst_n = 1'b1;
    chk_en = 1'b1;
    cyc();

    // Spawn
    pulse_start();
    check("spawn_x", int'(sif.char_x), 300);
    check("spawn_y", int'(sif.char_y), 150);
    check("spawn_hp", int'(sif.hp), 20);
    check("spawn_vis", int'(sif.char_vis), 1);
    check("spawn_state", int'(sif.state), 1);

    // Right edge saturation, then left, then opposing buttons
    sif.btn_right = 1'b1;
    frames(100);
    check("right_clamp_x", int'(sif.char_x), 386);
    sif.btn_right = 1'b0;
    sif.btn_left  = 1'b1;
    frames(5);
    check("left_5_x", int'(sif.char_x), 376);
    sif.btn_right = 1'b1;
    frames(5);
    check("opposed_x", int'(sif.char_x), 376);
    sif.btn_right = 1'b0;
    sif.btn_left  = 1'b0;

    // Top edge saturation
    pulse_start();
    sif.btn_up = 1'b1;
    frames(30);
    check("up_clamp_y", int'(sif.char_y), 100);
    sif.btn_up = 1'b0;

    // Hit, ignored second hit, blink, recovery
    pulse_hit();
    check("hit1_hp", int'(sif.hp), 16);
    check("hit1_state", int'(sif.state), 2);
    check("hit1_vis", int'(sif.char_vis), 1);
    pulse_hit();
    check("hit_ignored_hp", int'(sif.hp), 16);
    frames(1);
    check("blink_f1_vis", int'(sif.char_vis), 0);
    frames(4);
    check("blink_f5_vis", int'(sif.char_vis), 1);
    frames(54);
    check("inv_f59_state", int'(sif.state), 2);
    frames(1);
    check("inv_end_state", int'(sif.state), 1);
    check("inv_end_vis", int'(sif.char_vis), 1);

    // Five spaced hits to death, position frozen, respawn
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      pulse_hit();
      if (i < 4) frames(61);
    end
    check("dead_hp", int'(sif.hp), 0);
    check("dead_flag", int'(sif.dead), 1);
    check("dead_state", int'(sif.state), 3);
    sif.btn_right = 1'b1;
    frames(3);
    check("dead_frozen_x", int'(sif.char_x), 300);
    sif.btn_right = 1'b0;
    pulse_start();
    check("respawn_hp", int'(sif.hp), 20);
    check("respawn_x", int'(sif.char_x), 300);
    check("respawn_y", int'(sif.char_y), 150);

    // Hit and tick together with down held
    sif.btn_down   = 1'b1;
    sif.hit        = 1'b1;
    sif.frame_tick = 1'b1;
    cyc();
    check("hit_tick_hp", int'(sif.hp), 16);
    check("hit_tick_y", int'(sif.char_y), 152);
    check("hit_tick_state", int'(sif.state), 2);
    frames(3);
    sif.btn_down = 1'b0;

    // Asynchronous reset in the middle of invulnerability
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("async");
    cyc();
    check_reset_values("async_edge");
    rst_n = 1'b1;
    cyc();
    cyc();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
